// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback select pipeline.
package wb_pkg;

   localparam int unsigned WB_WIDTH = 32;
   localparam int unsigned WB_NSRC  = 3;
   localparam int unsigned WB_AW    = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_prio_mux.sv
// Priority selector: the lowest-index set flag wins; with no flag set, the last
// source (ALU result) is chosen.
module wb_prio_mux #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 3
) (
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       src_sel,
   output logic [WIDTH-1:0]      sel_data
);

   always_comb begin
      sel_data = src_data[(NSRC-1)*WIDTH +: WIDTH];
      // Walk from the highest index down so the lowest set flag is applied last.
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (src_sel[NSRC-1-k]) begin
            sel_data = src_data[(NSRC-1-k)*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback source select with a two-entry (output + skid) handshake buffer.
module wb_select_pipe
   import wb_pkg::*;
#(
   parameter int unsigned WIDTH    = WB_WIDTH,
   parameter int unsigned NSRC     = WB_NSRC,
   parameter int unsigned AW       = WB_AW,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       src_sel,
   input  logic [AW-1:0]         in_addr,
   input  logic                  in_float,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [AW-1:0]         out_addr,
   output logic                  out_float,
   output logic                  out_we
);

   wb_state_e        state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
   logic [AW-1:0]    out_addr_q, out_addr_d, skid_addr_q, skid_addr_d;
   logic             out_float_q, out_float_d, skid_float_q, skid_float_d;
   logic             out_we_q, out_we_d, skid_we_q, skid_we_d;

   logic [WIDTH-1:0] sel_data;
   logic             new_we;
   logic             accept, drain;

   wb_prio_mux #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC)
   ) u_mux (
      .src_data (src_data),
      .src_sel  (src_sel),
      .sel_data (sel_data)
   );

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;
   assign new_we    = !((ZERO_REG != 0) && !in_float && (in_addr == '0));

   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_float = out_float_q;
   assign out_we    = out_we_q;

   always_comb begin
      state_d      = state_q;
      out_data_d   = out_data_q;
      out_addr_d   = out_addr_q;
      out_float_d  = out_float_q;
      out_we_d     = out_we_q;
      skid_data_d  = skid_data_q;
      skid_addr_d  = skid_addr_q;
      skid_float_d = skid_float_q;
      skid_we_d    = skid_we_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               out_data_d  = sel_data;
               out_addr_d  = in_addr;
               out_float_d = in_float;
               out_we_d    = new_we;
               state_d     = HALF;
            end
         end
         HALF: begin
            if (accept && drain) begin
               out_data_d  = sel_data;
               out_addr_d  = in_addr;
               out_float_d = in_float;
               out_we_d    = new_we;
            end else if (accept) begin
               skid_data_d  = sel_data;
               skid_addr_d  = in_addr;
               skid_float_d = in_float;
               skid_we_d    = new_we;
               state_d      = FULL;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               out_data_d  = skid_data_q;
               out_addr_d  = skid_addr_q;
               out_float_d = skid_float_q;
               out_we_d    = skid_we_q;
               state_d     = HALF;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         out_data_q   <= '0;
         out_addr_q   <= '0;
         out_float_q  <= 1'b0;
         out_we_q     <= 1'b0;
         skid_data_q  <= '0;
         skid_addr_q  <= '0;
         skid_float_q <= 1'b0;
         skid_we_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_addr_q   <= out_addr_d;
         out_float_q  <= out_float_d;
         out_we_q     <= out_we_d;
         skid_data_q  <= skid_data_d;
         skid_addr_q  <= skid_addr_d;
         skid_float_q <= skid_float_d;
         skid_we_q    <= skid_we_d;
      end
   end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed-vector bench for wb_select_pipe with hand-computed expectations.
module tb_wb_select_pipe;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned NSRC  = 3;
   localparam int unsigned AW    = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [NSRC*WIDTH-1:0] src_data;
   logic [NSRC-1:0]       src_sel;
   logic [AW-1:0]         in_addr;
   logic                  in_float;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic [AW-1:0]         out_addr;
   logic                  out_float;
   logic                  out_we;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   wb_select_pipe #(
      .WIDTH    (WIDTH),
      .NSRC     (NSRC),
      .AW       (AW),
      .ZERO_REG (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .src_data  (src_data),
      .src_sel   (src_sel),
      .in_addr   (in_addr),
      .in_float  (in_float),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_float (out_float),
      .out_we    (out_we)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request whose payload comes from source 0.
   task automatic drive(input logic [WIDTH-1:0] d, input logic [AW-1:0] a, input logic f);
      in_valid = 1'b1;
      src_data = {32'h300, 32'h200, d};
      src_sel  = 3'b001;
      in_addr  = a;
      in_float = f;
   endtask

   initial begin
      logic [2:0]       sel_tab [3];
      logic [WIDTH-1:0] exp_tab [3];
      logic [AW-1:0]    za_tab  [3];
      logic             zf_tab  [3];
      logic             zw_tab  [3];

      sel_tab = '{3'b011, 3'b010, 3'b000};
      exp_tab = '{32'h100, 32'h200, 32'h300};
      za_tab  = '{5'd0, 5'd0, 5'd5};
      zf_tab  = '{1'b0, 1'b1, 1'b0};
      zw_tab  = '{1'b0, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; src_data = '0; src_sel = '0;
      in_addr = '0; in_float = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
      check("rst_data",  out_data, 0);
      check("rst_addr",  out_addr, 0);
      check("rst_float", out_float, 0);
      check("rst_we",    out_we, 0);

      // priority selection
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         src_data = {32'h300, 32'h200, 32'h100};
         src_sel  = sel_tab[i];
         in_addr  = 5'd3;
         in_float = 1'b0;
         tick();
         in_valid = 1'b0;
         check("prio_valid", out_valid, 1);
         check("prio_data",  out_data, exp_tab[i]);
         tick();
         check("prio_empty", out_valid, 0);
      end

      // streaming with out_ready held high
      for (int i = 0; i < 8; i++) begin
         drive(32'h1000 + i, 5'(i + 1), 1'b0);
         check("stream_ready", in_ready, 1);
         tick();
         check("stream_valid", out_valid, 1);
         check("stream_data",  out_data, 32'h1000 + i);
         check("stream_addr",  out_addr, i + 1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", out_valid, 0);

      // backpressure: fill both entries
      out_ready = 1'b0;
      drive(32'hAAAA, 5'd1, 1'b0);
      tick();
      drive(32'hBBBB, 5'd2, 1'b1);
      tick();
      in_valid = 1'b0;
      check("bp_ready_full", in_ready, 0);
      check("bp_valid",      out_valid, 1);
      check("bp_data_a",     out_data, 32'hAAAA);
      tick();
      tick();
      check("bp_hold_data",  out_data, 32'hAAAA);
      check("bp_hold_addr",  out_addr, 1);
      check("bp_hold_float", out_float, 0);
      check("bp_hold_ready", in_ready, 0);
      out_ready = 1'b1;
      tick();
      check("bp_drain_b",      out_data, 32'hBBBB);
      check("bp_drain_bfloat", out_float, 1);
      check("bp_drain_valid",  out_valid, 1);
      check("bp_ready_half",   in_ready, 1);
      tick();
      check("bp_empty", out_valid, 0);
      check("bp_ready", in_ready, 1);

      // zero register write-enable qualification
      for (int i = 0; i < 3; i++) begin
         drive(32'h55 + i, za_tab[i], zf_tab[i]);
         tick();
         in_valid = 1'b0;
         check("zr_valid", out_valid, 1);
         check("zr_we",    out_we, zw_tab[i]);
         check("zr_addr",  out_addr, za_tab[i]);
         tick();
      end

      // reset while FULL discards both entries
      out_ready = 1'b0;
      drive(32'hA0A0, 5'd7, 1'b0);
      tick();
      drive(32'hB0B0, 5'd8, 1'b0);
      tick();
      check("mid_full", in_ready, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_valid", out_valid, 0);
      check("mid_ready", in_ready, 1);
      check("mid_data",  out_data, 0);
      check("mid_we",    out_we, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_no_ghost", out_valid, 0);
      end

      // simultaneous accept and drain in HALF
      out_ready = 1'b0;
      drive(32'hA1A1, 5'd9, 1'b0);
      tick();
      check("sim_half_a", out_data, 32'hA1A1);
      drive(32'hC1C1, 5'd10, 1'b0);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("sim_valid", out_valid, 1);
      check("sim_ready", in_ready, 1);
      check("sim_data",  out_data, 32'hC1C1);
      check("sim_addr",  out_addr, 10);
      tick();
      check("sim_empty", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
